// File: rtl/regfile_rename_pkg.sv
// Shared widths, read-port response bundle and helpers for the renamed register file.
// Optional commit bypass on the read ports: REGFILE_COMMIT_BYPASS_EN.
package regfile_rename_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int TAG_SIZE   = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                busy;
        logic [TAG_SIZE-1:0] tag;
        logic [DATA_W-1:0]   val;
    } rd_resp_t;

    function automatic logic writes_rd(
        input logic                  en,
        input logic [REG_ADDR_W-1:0] rd
    );
        return en && (rd != '0);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational operand lookup: value or pending producer tag.
// With REGFILE_COMMIT_BYPASS_EN a matching same-cycle commit is forwarded.
module regfile_read_port
    import regfile_rename_pkg::*;
#(
    parameter int NREG = NUM_REGS,
    parameter int TAGW = TAG_SIZE,
    parameter int XLEN = DATA_W
) (
    input  logic [REG_ADDR_W-1:0] rs_in,
    input  logic [XLEN-1:0]       regs_in [NREG],
    input  logic [NREG-1:0]       busy_in,
    input  logic [TAGW-1:0]       tags_in [NREG],
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic                  commit_en_in,
    input  logic [TAGW-1:0]       commit_tag_in,
    input  logic [REG_ADDR_W-1:0] commit_rd_in,
    input  logic [XLEN-1:0]       commit_val_in,
`endif
    output logic                  busy_out,
    output logic [TAGW-1:0]       tag_out,
    output logic [XLEN-1:0]       val_out
);

    logic nz;

    always_comb begin
        nz       = (rs_in != '0);
        busy_out = nz && busy_in[rs_in];
        tag_out  = tags_in[rs_in];
        val_out  = nz ? regs_in[rs_in] : '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        // The producer is retiring right now; hand its result over early.
        if (commit_en_in && nz && (commit_rd_in == rs_in) &&
            busy_in[rs_in] && (tags_in[rs_in] == commit_tag_in)) begin
            busy_out = 1'b0;
            val_out  = commit_val_in;
        end
`endif
    end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy/ROB-tag rename state.
// Define REGFILE_COMMIT_BYPASS_EN to forward same-cycle commits to the read ports.
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int NREG = NUM_REGS,
    parameter int TAGW = TAG_SIZE,
    parameter int XLEN = DATA_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  commit_en_in,
    input  logic [TAGW-1:0]       commit_tag_in,
    input  logic [REG_ADDR_W-1:0] commit_rd_in,
    input  logic [XLEN-1:0]       commit_val_in,
    input  logic                  issue_en_in,
    input  logic [REG_ADDR_W-1:0] issue_rd_in,
    input  logic [TAGW-1:0]       issue_tag_in,
    input  logic [REG_ADDR_W-1:0] rs1_in,
    input  logic [REG_ADDR_W-1:0] rs2_in,
    output logic                  rs1_busy_out,
    output logic                  rs2_busy_out,
    output logic [TAGW-1:0]       rs1_tag_out,
    output logic [TAGW-1:0]       rs2_tag_out,
    output logic [XLEN-1:0]       rs1_val_out,
    output logic [XLEN-1:0]       rs2_val_out
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [TAGW-1:0] tags_q [NREG];
    logic [TAGW-1:0] tags_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        regs_d = regs_q;
        tags_d = tags_q;
        busy_d = busy_q;
        if (rdy_in) begin
            if (writes_rd(commit_en_in, commit_rd_in)) begin
                regs_d[commit_rd_in] = commit_val_in;
                // Only the newest producer may release the rename.
                if (tags_q[commit_rd_in] == commit_tag_in)
                    busy_d[commit_rd_in] = 1'b0;
            end
            if (clear_in) begin
                busy_d = '0;
            end else if (writes_rd(issue_en_in, issue_rd_in)) begin
                busy_d[issue_rd_in] = 1'b1;
                tags_d[issue_rd_in] = issue_tag_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            regs_q <= '{default: '0};
            tags_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            tags_q <= tags_d;
            busy_q <= busy_d;
        end
    end

    regfile_read_port #(
        .NREG (NREG),
        .TAGW (TAGW),
        .XLEN (XLEN)
    ) u_rs1 (
        .rs_in         (rs1_in),
        .regs_in       (regs_q),
        .busy_in       (busy_q),
        .tags_in       (tags_q),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_en_in  (commit_en_in),
        .commit_tag_in (commit_tag_in),
        .commit_rd_in  (commit_rd_in),
        .commit_val_in (commit_val_in),
`endif
        .busy_out      (rs1_busy_out),
        .tag_out       (rs1_tag_out),
        .val_out       (rs1_val_out)
    );

    regfile_read_port #(
        .NREG (NREG),
        .TAGW (TAGW),
        .XLEN (XLEN)
    ) u_rs2 (
        .rs_in         (rs2_in),
        .regs_in       (regs_q),
        .busy_in       (busy_q),
        .tags_in       (tags_q),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_en_in  (commit_en_in),
        .commit_tag_in (commit_tag_in),
        .commit_rd_in  (commit_rd_in),
        .commit_val_in (commit_val_in),
`endif
        .busy_out      (rs2_busy_out),
        .tag_out       (rs2_tag_out),
        .val_out       (rs2_val_out)
    );

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file plus per-register rename status (busy bit, ROB tag).
- Consumer end of the ROB commit bus: receives commits (en_commit, ROB_Number, Reg_Number, Reg_Val) and the flush strobe (clear).
- Issue side renames rd to the allocated ROB tag.
- Decode/RS side reads two operands per cycle. Each read returns either a value or a pending ROB tag.

Parameters:
- NREG, 32, number of architectural registers (x0..x31)
- TAGW, 5, ROB tag width (matches ROB depth 32)
- XLEN, 32, data width

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global ready; state frozen when 0
- clear_in  in  1  flush from ROB (mispredict / jump)
- commit_en_in  in  1  commit valid
- commit_tag_in  in  TAGW  ROB entry being committed
- commit_rd_in  in  5  destination register of commit (0 = no write)
- commit_val_in  in  XLEN  committed value
- issue_en_in  in  1  instruction issued with a destination
- issue_rd_in  in  5  destination register to rename
- issue_tag_in  in  TAGW  ROB tag allocated to it
- rs1_in, rs2_in  in  5  source register indices
- rs1_busy_out, rs2_busy_out  out  1  operand pending
- rs1_tag_out, rs2_tag_out  out  TAGW  producer ROB tag (valid when busy)
- rs1_val_out, rs2_val_out  out  XLEN  operand value (valid when not busy)

Behaviour:
- Reset (rst_in==0 at posedge): all regs = 0, all busy = 0, all tags = 0.
  - Outputs are combinational, so after reset they read value 0, busy 0, tag 0.
- rdy_in==0: no state update. Outputs stay combinational from current state.
- Commit (posedge, rdy_in, commit_en_in, commit_rd_in!=0):
  - reg[rd] <= commit_val_in.
  - busy[rd] <= 0 only if tag[rd]==commit_tag_in. Otherwise a newer producer owns rd and stays busy.
- Issue (posedge, rdy_in, issue_en_in, issue_rd_in!=0, clear_in==0): busy[rd] <= 1, tag[rd] <= issue_tag_in.
- Issue and commit to the same rd in the same cycle: issue wins for busy/tag; the value write still occurs.
- Clear (clear_in==1):
  - All busy <= 0 next edge.
  - Issue in the same cycle is ignored.
  - A commit presented in the same cycle is still written. The ROB raises clear alongside the jal/jalr link commit.
- x0: never written, never busy. Reads of x0 return value 0, busy 0.
- Read ports are combinational from state, with commit bypass (see Optional Feature).
- No same-cycle issue bypass: a read of the rd being issued returns the pre-issue state. Issue logic handles self-dependence.
- Write latency: 1 cycle. Read latency: 0.
- Reset during active commit/issue: reset dominates; all state zeroed.

Optional Feature:
- REGFILE_COMMIT_BYPASS_EN defined:
  - If commit_en_in && commit_rd_in==rsX_in && rsX_in!=0 && busy[rsX] && tag[rsX]==commit_tag_in:
    - rsX_busy_out=0, rsX_val_out=commit_val_in.
  - Saves one cycle of operand wait.
- Undefined: reads reflect registered state only; the committed value appears next cycle.

Decomposition:
- Shared def.v: `InstSize, `RegAddrSize, `zero, `one. Add `TagSize for the ROB tag width if absent.
- One natural sub-module: regfile_read_port.
  - Combinational lookup + optional commit bypass for one source index.
  - Instantiated twice (rs1, rs2).

Test Plan:
- Reset: drive rst_in=0 one edge, release -> rs1=5 reads val 0, busy 0, tag 0.
- Issue x5 tag 3, then commit tag 3 rd 5 val 0xDEADBEEF:
  - After issue: rs1=5 reads busy 1, tag 3.
  - After commit: busy 0, val 0xDEADBEEF.
- Rename overwrite: issue x7 tag 2, then issue x7 tag 9, then commit tag 2 rd 7 val 0x11 -> x7 busy 1, tag 9; reg value 0x11 stored.
- Same-cycle issue x4 tag 6 + commit x4 tag 1 val 0x22 (x4 previously tag 1) -> x4 busy 1, tag 6; value 0x22.
- Clear with simultaneous commit rd 1 val 0x104 and issue x8 tag 5:
  - All busy cleared; x1=0x104; x8 not busy.
- x0 and bypass:
  - Issue rd 0 -> x0 never busy.
  - With REGFILE_COMMIT_BYPASS_EN: x3 busy tag 4; same-cycle commit tag 4 val 0x55 -> rs2_busy_out=0, rs2_val_out=0x55 combinationally.
